// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains 32-bit FIFO words onto a UART TX line, LSB byte first (even parity option: FIFO_UART_TX_PARITY_EN)
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WIDTH        = 32
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    input  logic             fifo_ack_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_rd_en_o,
    output logic             uart_tx_o,
    output logic             busy_o,
    output logic             word_done_o
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_ACK, S_START, S_DATA, S_STOP, S_PARITY
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_ACK, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             done_q, done_d;
    logic             baud_wrap;
    logic             rd_req;

    assign baud_wrap = (baud_q == BAUD_LAST);

    // A read is only requested from IDLE; the word_done cycle itself never reads,
    // which leaves a fixed idle-high gap between back-to-back words.
    assign rd_req = rst_sys_n & enable_i & ~fifo_empty_i & ~done_q & (state_q == S_IDLE);

`ifdef FIFO_UART_TX_PARITY_EN
    logic [7:0] cur_byte;
    assign cur_byte = word_q[{idx_q, 3'b000} +: 8];
`endif

    // State, counters, shift word and done pulse registers
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    // Next-state: baud counter wraps drive every bit/state advance, and restart at 0 on entry
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (rd_req) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                baud_d = '0;
                if (fifo_ack_i) begin
                    word_d  = fifo_data_i;
                    idx_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (idx_q == 2'd3) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: line level decoded from state so reset drives the line high at once
    always_comb begin
        uart_tx_o    = 1'b1;
        busy_o       = (state_q != S_IDLE);
        fifo_rd_en_o = rd_req;
        word_done_o  = done_q;
        case (state_q)
            S_START:  uart_tx_o = 1'b0;
            S_DATA:   uart_tx_o = word_q[{idx_q, bit_q}];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: uart_tx_o = ^cur_byte;
`endif
            default:  uart_tx_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        enable_i;
    logic        fifo_empty_i;
    logic        fifo_ack_i;
    logic [31:0] fifo_data_i;
    logic        fifo_rd_en_o;
    logic        uart_tx_o;
    logic        busy_o;
    logic        word_done_o;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(32)) dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .enable_i     (enable_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_ack_i   (fifo_ack_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .uart_tx_o    (uart_tx_o),
        .busy_o       (busy_o),
        .word_done_o  (word_done_o)
    );

    always #5 clk_sys = ~clk_sys;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // FIFO emulator: registered, sticky ack answering each read request
    logic [31:0] fq[$];
    logic        rd_seen   = 1'b0;
    logic        nack_next = 1'b0;

    always @(posedge clk_sys) begin
        #1;
        if (rd_seen) begin
            rd_seen = 1'b0;
            if (nack_next) begin
                fq.delete();
                fifo_ack_i = 1'b0;
                nack_next  = 1'b0;
            end else if (fq.size() > 0) begin
                fifo_ack_i  = 1'b1;
                fifo_data_i = fq.pop_front();
            end else begin
                fifo_ack_i = 1'b0;
            end
        end
        fifo_empty_i = (fq.size() == 0);
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Behavioural model: a queue of per-cycle expectations {rd, tx, busy, done, wait_ack}
    typedef struct packed {
        logic rd;
        logic tx;
        logic busy;
        logic done;
        logic wt;
    } rec_t;

    rec_t plan[$];
    rec_t mdl_e;

    task automatic push_frame(input logic [31:0] w);
        logic [7:0] b;
        logic       bl[$];
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            bl.delete();
            bl.push_back(1'b0);
            for (int j = 0; j < 8; j++) bl.push_back(b[j]);
`ifdef FIFO_UART_TX_PARITY_EN
            bl.push_back(^b);
`endif
            bl.push_back(1'b1);
            for (int j = 0; j < bl.size(); j++)
                for (int k = 0; k < CPB; k++)
                    plan.push_back({1'b0, bl[j], 1'b1, 1'b0, 1'b0});
        end
        plan.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    endtask

    // Event logs and a simple UART receiver
    int   rd_times[$];
    int   done_times[$];
    int   rx_starts[$];
    int   rx_bytes[$];
    int   rx_par[$];
    logic busy_hist [0:8191];
    int   rx_pos = -1;
    int   rx_k;
    logic [7:0] rx_sh;

    task automatic clear_events();
        rd_times.delete();
        done_times.delete();
        rx_starts.delete();
        rx_bytes.delete();
        rx_par.delete();
    endtask

    always @(negedge clk_sys) begin
        if (!rst_sys_n) begin
            plan.delete();
            rx_pos  = -1;
            rd_seen = 1'b0;
        end else begin
            if (plan.size() > 0) begin
                mdl_e = plan.pop_front();
            end else begin
                mdl_e = {enable_i & ~fifo_empty_i, 1'b1, 1'b0, 1'b0, 1'b0};
                if (mdl_e.rd) plan.push_back({1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
            end
            check("cycle_rd_tx_busy_done", {fifo_rd_en_o, uart_tx_o, busy_o, word_done_o},
                  {mdl_e.rd, mdl_e.tx, mdl_e.busy, mdl_e.done});
            if (mdl_e.wt && fifo_ack_i) push_frame(fifo_data_i);

            rd_seen = fifo_rd_en_o;
            if (fifo_rd_en_o) rd_times.push_back(cyc);
            if (word_done_o) done_times.push_back(cyc);
            if (cyc < 8192) busy_hist[cyc] = busy_o;

            if (rx_pos < 0) begin
                if (!uart_tx_o) begin
                    rx_pos = 0;
                    rx_sh  = '0;
                    rx_starts.push_back(cyc);
                end
            end else begin
                rx_pos++;
                if (rx_pos % CPB == CPB / 2) begin
                    rx_k = rx_pos / CPB;
                    if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k-1] = uart_tx_o;
                    else if (rx_k == BITS - 1) begin
                        rx_bytes.push_back(int'(rx_sh));
                        rx_pos = -1;
                    end else if (rx_k == 9) rx_par.push_back(int'(uart_tx_o));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        int target;
        rst_sys_n    = 1'b0;
        enable_i     = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_ack_i   = 1'b0;
        fifo_data_i  = '0;
        #1;
        check("reset_tx", uart_tx_o, 1);
        check("reset_rd", fifo_rd_en_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", word_done_o, 0);
        repeat (3) @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;

        // Disabled: FIFO not empty but nothing must be read
        fq.push_back(32'hA5C3_0F81);
        clear_events();
        repeat (100) @(posedge clk_sys);
        #1;
        check("t1_no_read", rd_times.size(), 0);
        check("t1_tx_idle", uart_tx_o, 1);
        check("t1_busy", busy_o, 0);

        // One word
        enable_i = 1'b1;
        n = 0;
        while (done_times.size() < 1 && n < 1000) begin @(posedge clk_sys); n++; end
        #1 enable_i = 1'b0;
        check("t2_done_count", done_times.size(), 1);
        check("t2_rd_count", rd_times.size(), 1);
        check("t2_rd_to_start", at(rx_starts, 0) - at(rd_times, 0), 2);
        check("t2_start_to_done", at(done_times, 0) - at(rx_starts, 0), BITS * 4 * CPB);
        check("t2_byte0", at(rx_bytes, 0), 32'h81);
        check("t2_byte1", at(rx_bytes, 1), 32'h0F);
        check("t2_byte2", at(rx_bytes, 2), 32'hC3);
        check("t2_byte3", at(rx_bytes, 3), 32'hA5);

        // Two words back to back
        repeat (5) @(posedge clk_sys);
        #1 clear_events();
        fq.push_back(32'h0123_4567);
        fq.push_back(32'h89AB_CDEF);
        enable_i = 1'b1;
        n = 0;
        while (done_times.size() < 2 && n < 1000) begin @(posedge clk_sys); n++; end
        #1 enable_i = 1'b0;
        check("t3_done_count", done_times.size(), 2);
        check("t3_rd_after_done", at(rd_times, 1) - at(done_times, 0), 1);
        check("t3_idle_gap", at(rx_starts, 4) - at(done_times, 0), 3);
        check("t3_w1_byte0", at(rx_bytes, 0), 32'h67);
        check("t3_w2_byte0", at(rx_bytes, 4), 32'hEF);
        check("t3_w2_byte3", at(rx_bytes, 7), 32'h89);

        // Empty race: ack=0 after the read request
        repeat (5) @(posedge clk_sys);
        #1 clear_events();
        nack_next = 1'b1;
        fq.push_back(32'h0000_0055);
        enable_i = 1'b1;
        n = 0;
        while (rd_times.size() < 1 && n < 50) begin @(posedge clk_sys); n++; end
        #1 enable_i = 1'b0;
        repeat (6) @(posedge clk_sys);
        #1;
        r = at(rd_times, 0);
        check("t4_rd_count", rd_times.size(), 1);
        check("t4_busy_wait", busy_hist[r+1], 1);
        check("t4_busy_drop", busy_hist[r+2], 0);
        check("t4_no_done", done_times.size(), 0);
        check("t4_no_start", rx_starts.size(), 0);

        // Enable dropped mid-word
        clear_events();
        fq.push_back(32'h1122_3344);
        fq.push_back(32'hDEAD_BEEF);
        enable_i = 1'b1;
        n = 0;
        while (rx_bytes.size() < 1 && n < 200) begin @(posedge clk_sys); n++; end
        #1 enable_i = 1'b0;
        n = 0;
        while (done_times.size() < 1 && n < 500) begin @(posedge clk_sys); n++; end
        repeat (30) @(posedge clk_sys);
        #1;
        check("t5_rd_count", rd_times.size(), 1);
        check("t5_byte_count", rx_bytes.size(), 4);
        check("t5_byte0", at(rx_bytes, 0), 32'h44);
        check("t5_byte1", at(rx_bytes, 1), 32'h33);
        check("t5_byte2", at(rx_bytes, 2), 32'h22);
        check("t5_byte3", at(rx_bytes, 3), 32'h11);
        fq.delete();
        repeat (3) @(posedge clk_sys);

        // Reset in the middle of byte 2, data bit 3
        #1 clear_events();
        fq.push_back(32'hA5F0_1234);
        fq.push_back(32'h1234_8381);
        enable_i = 1'b1;
        n = 0;
        while (rd_times.size() < 1 && n < 50) begin @(posedge clk_sys); n++; end
        r = at(rd_times, 0);
        target = r + 2 + 2 * BITS * CPB + 4 * CPB + 1;
        n = 0;
        while (cyc < target && n < 1000) begin @(posedge clk_sys); #1; n++; end
        #1;
        check("t6_pre_tx", uart_tx_o, 0);
        check("t6_pre_busy", busy_o, 1);
        rst_sys_n = 1'b0;
        #1;
        check("t6_rst_tx", uart_tx_o, 1);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_rd", fifo_rd_en_o, 0);
        clear_events();
        repeat (2) @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        n = 0;
        while (done_times.size() < 1 && n < 500) begin @(posedge clk_sys); n++; end
        #1 enable_i = 1'b0;
        check("t6_done_count", done_times.size(), 1);
        check("t6_byte0", at(rx_bytes, 0), 32'h81);
        check("t6_byte1", at(rx_bytes, 1), 32'h83);
        check("t6_byte2", at(rx_bytes, 2), 32'h34);
        check("t6_byte3", at(rx_bytes, 3), 32'h12);
`ifdef FIFO_UART_TX_PARITY_EN
        check("t6_par_81", at(rx_par, 0), 0);
        check("t6_par_83", at(rx_par, 1), 1);
`endif
        repeat (5) @(posedge clk_sys);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 32-bit word FIFO on the system clock domain.
- Pops one word at a time and serialises it over a UART TX line as 4 byte frames, least significant byte first.
- Lets software drain logged or buffered data to the ZedBoard USB-UART without CPU involvement per byte.

Parameters:
- CLKS_PER_BIT, 434, clk_sys cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- WIDTH, 32, FIFO word width; fixed at 32, giving 4 bytes per word.

Ports:
- clk_sys  input  1  system clock; single clock domain.
- rst_sys_n  input  1  system reset, asynchronous assert, active-low.
- enable_i  input  1  drain enable; 1 = fetch and send words.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_ack_i  input  1  FIFO read acknowledge, registered in the FIFO.
- fifo_data_i  input  32  FIFO read data, registered in the FIFO.
- fifo_rd_en_o  input→FIFO  output  1  FIFO read request, single-cycle pulse.
- uart_tx_o  output  1  serial TX line; idle high.
- busy_o  output  1  high from the read request until the last stop bit ends.
- word_done_o  output  1  one-cycle pulse when a word's 4th stop bit completes.

Behaviour:
- Reset values: uart_tx_o=1, fifo_rd_en_o=0, busy_o=0, word_done_o=0.
  - FSM resets to IDLE. Bit counter, baud counter and byte index reset to 0.
  - Reset asserted mid-frame forces uart_tx_o=1 immediately (asynchronous). The partial word is discarded.
- FSM states and transitions:
  - IDLE: if enable_i=1 and fifo_empty_i=0, drive fifo_rd_en_o=1 for this cycle only and go to WAIT_ACK. Otherwise stay in IDLE.
  - WAIT_ACK (exactly one cycle): sample fifo_ack_i and fifo_data_i.
    - If ack=1, latch the 32-bit word into the shift register, set byte index to 0, and go to START.
    - If ack=0 (empty race), go to IDLE with no output activity.
    - fifo_rd_en_o=0 here, because the FIFO's ack is sticky while read enable is low.
  - START: uart_tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send byte[index] bits 0..7, LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to PARITY if the option is compiled in, otherwise to STOP.
  - STOP: uart_tx_o=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
    - If index<3: increment index and go to START. There is no idle gap between bytes.
    - If index=3: pulse word_done_o and go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit/state advance happens on the wrap cycle.
  - The counter is cleared on every state entry.
- Latency:
  - Read request to the start bit's first cycle is 2 clk_sys cycles.
  - One word takes 40·CLKS_PER_BIT cycles on the line, or 44 with parity.
  - Back-to-back words: the next fifo_rd_en_o pulse occurs in the IDLE cycle immediately after word_done_o. This gives a 3-cycle idle-high gap between words.
- busy_o: 1 in every state except IDLE.
- enable_i deasserted mid-word: the current word completes fully, and no further read is issued.
- Bounds:
  - fifo_rd_en_o is never high for two consecutive cycles.
  - At most one word is in flight.
  - The block never issues a read when fifo_empty_i=1.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits.
- Undefined: 8N1 framing, 10-bit frames, no PARITY state present.

Test Plan:
1. Reset, then hold rst_sys_n=1, enable_i=0, fifo_empty_i=0 for 100 cycles -> fifo_rd_en_o stays 0, uart_tx_o=1, busy_o=0.
2. CLKS_PER_BIT=4, enable_i=1, FIFO returns ack=1 with data 0xA5C3_0F81 -> one rd_en pulse; start bit 2 cycles later. Line carries bytes 0x81, 0x0F, 0xC3, 0xA5 (LSB first, 4 cycles per bit). word_done_o pulses once, 160 cycles after the start bit begins.
3. Two words queued, enable held high -> second rd_en pulse exactly 1 cycle after word_done_o. Line idle-high for 3 cycles between the first word's final stop bit and the second start bit.
4. rd_en issued but fifo_ack_i=0 in the following cycle -> back to IDLE, uart_tx_o stays 1, busy_o drops after 2 cycles, no word_done_o.
5. Drop enable_i after byte 1 of word 0x1122_3344 -> all 4 bytes (0x44, 0x33, 0x22, 0x11) sent, then no further rd_en although fifo_empty_i=0.
6. Assert rst_sys_n=0 mid DATA bit of byte 2 -> uart_tx_o=1 and busy_o=0 immediately. After release, the next word starts from byte 0. With FIFO_UART_TX_PARITY_EN, byte 0x81 carries parity bit 0 and byte 0x83 carries parity bit 1.
